// File: rtl/cpu_pkg.sv
// cpu_pkg: shared RV32I opcodes, ALU ops, immediate types and the ID/EX register layout
package cpu_pkg;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        logic        alu_src_imm;
        logic        alu_src_pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
        logic [2:0]  funct3;
    } idex_t;

    // alt selects SUB/SRA; callers decide whether instr[30] is meaningful
    function automatic alu_op_t f3_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_type_t t);
        case (t)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational RV32I decode into ID/EX control fields, source-use masks and immediate
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [31:0] i_instr,
    output idex_t       o_ctrl,
    output logic        o_use_rs1,
    output logic        o_use_rs2
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [4:0] w_rd;
    logic       w_writes;
    imm_type_t  w_imm_type;

    assign w_opc = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_rd  = i_instr[11:7];

    // per-opcode control; unknown opcodes leave everything 0 except illegal
    always_comb begin
        o_ctrl     = '0;
        o_use_rs1  = 1'b0;
        o_use_rs2  = 1'b0;
        w_writes   = 1'b0;
        w_imm_type = IMM_NONE;
        case (w_opc)
            OPC_LUI: begin
                w_imm_type = IMM_U; o_ctrl.alu_op = ALU_PASSB; o_ctrl.alu_src_imm = 1'b1; w_writes = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm_type = IMM_U; o_ctrl.alu_src_imm = 1'b1; o_ctrl.alu_src_pc = 1'b1; w_writes = 1'b1;
            end
            OPC_JAL: begin
                w_imm_type = IMM_J; o_ctrl.alu_src_imm = 1'b1; o_ctrl.jump = 1'b1; w_writes = 1'b1;
            end
            OPC_JALR: begin
                w_imm_type = IMM_I; o_ctrl.alu_src_imm = 1'b1; o_ctrl.jump = 1'b1; w_writes = 1'b1;
                o_use_rs1 = 1'b1; o_ctrl.funct3 = w_f3;
            end
            OPC_BRANCH: begin
                w_imm_type = IMM_B; o_ctrl.alu_op = ALU_SUB; o_ctrl.branch = 1'b1;
                o_use_rs1 = 1'b1; o_use_rs2 = 1'b1; o_ctrl.funct3 = w_f3;
            end
            OPC_LOAD: begin
                w_imm_type = IMM_I; o_ctrl.alu_src_imm = 1'b1; o_ctrl.mem_read = 1'b1; w_writes = 1'b1;
                o_use_rs1 = 1'b1; o_ctrl.funct3 = w_f3;
            end
            OPC_STORE: begin
                w_imm_type = IMM_S; o_ctrl.alu_src_imm = 1'b1; o_ctrl.mem_write = 1'b1;
                o_use_rs1 = 1'b1; o_use_rs2 = 1'b1; o_ctrl.funct3 = w_f3;
            end
            OPC_OPIMM: begin
                w_imm_type = IMM_I; o_ctrl.alu_op = f3_alu(w_f3, i_instr[30] & (w_f3 == 3'b101));
                o_ctrl.alu_src_imm = 1'b1; w_writes = 1'b1; o_use_rs1 = 1'b1; o_ctrl.funct3 = w_f3;
            end
            OPC_OP: begin
                o_ctrl.alu_op = f3_alu(w_f3, i_instr[30]); w_writes = 1'b1;
                o_use_rs1 = 1'b1; o_use_rs2 = 1'b1; o_ctrl.funct3 = w_f3;
            end
            default: o_ctrl.illegal = 1'b1;
        endcase
        o_ctrl.rd        = w_writes ? w_rd : 5'd0;
        o_ctrl.reg_write = w_writes & (w_rd != 5'd0);
        o_ctrl.rs1       = o_use_rs1 ? i_instr[19:15] : 5'd0;
        o_ctrl.rs2       = o_use_rs2 ? i_instr[24:20] : 5'd0;
        o_ctrl.imm       = gen_imm(i_instr, w_imm_type);
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with IF/ID and ID/EX registers, load-use stall and flush bubbles
module id_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    output logic [4:0]  rf_src1,
    output logic [4:0]  rf_src2,
    input  logic [31:0] rf_data1,
    input  logic [31:0] rf_data2,
    output logic        stall,
    output logic        idex_valid,
    output logic [31:0] idex_pc,
    output logic [31:0] idex_rs1_data,
    output logic [31:0] idex_rs2_data,
    output logic [31:0] idex_imm,
    output logic [4:0]  idex_rs1,
    output logic [4:0]  idex_rs2,
    output logic [4:0]  idex_rd,
    output logic [3:0]  idex_alu_op,
    output logic        idex_alu_src_imm,
    output logic        idex_alu_src_pc,
    output logic        idex_reg_write,
    output logic        idex_mem_read,
    output logic        idex_mem_write,
    output logic        idex_branch,
    output logic        idex_jump,
    output logic        idex_illegal,
    output logic [2:0]  idex_funct3
);

    logic        r_ifid_valid;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    idex_t       r_idex;
    idex_t       w_dec;
    idex_t       w_idex_d;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_hazard;

    instr_decoder u_dec (
        .i_instr   (r_ifid_instr),
        .o_ctrl    (w_dec),
        .o_use_rs1 (w_use_rs1),
        .o_use_rs2 (w_use_rs2)
    );

    assign rf_src1  = w_dec.rs1;
    assign rf_src2  = w_dec.rs2;
    assign w_hazard = r_ifid_valid & ex_mem_read & (ex_rd != 5'd0) &
                      ((w_use_rs1 & (w_dec.rs1 == ex_rd)) | (w_use_rs2 & (w_dec.rs2 == ex_rd)));
    assign stall    = w_hazard & ~flush;

    // IF/ID: hold on stall; flush kills the younger instruction regardless
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= 32'b0;
            r_ifid_pc    <= 32'b0;
        end else begin
            if (!stall) begin
                r_ifid_valid <= if_valid;
                r_ifid_instr <= if_instr;
                r_ifid_pc    <= if_pc;
            end
            if (flush) r_ifid_valid <= 1'b0;
        end
    end

    // next ID/EX: decoded instruction plus operands, or an all-zero bubble on flush/hazard
    always_comb begin
        w_idex_d          = w_dec;
        w_idex_d.valid    = r_ifid_valid;
        w_idex_d.pc       = r_ifid_pc;
        w_idex_d.rs1_data = rf_data1;
        w_idex_d.rs2_data = rf_data2;
        if (flush | w_hazard) w_idex_d = '0;
    end

    // ID/EX register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_idex <= '0;
        else        r_idex <= w_idex_d;
    end

    assign idex_valid       = r_idex.valid;
    assign idex_pc          = r_idex.pc;
    assign idex_rs1_data    = r_idex.rs1_data;
    assign idex_rs2_data    = r_idex.rs2_data;
    assign idex_imm         = r_idex.imm;
    assign idex_rs1         = r_idex.rs1;
    assign idex_rs2         = r_idex.rs2;
    assign idex_rd          = r_idex.rd;
    assign idex_alu_op      = r_idex.alu_op;
    assign idex_alu_src_imm = r_idex.alu_src_imm;
    assign idex_alu_src_pc  = r_idex.alu_src_pc;
    assign idex_reg_write   = r_idex.reg_write;
    assign idex_mem_read    = r_idex.mem_read;
    assign idex_mem_write   = r_idex.mem_write;
    assign idex_branch      = r_idex.branch;
    assign idex_jump        = r_idex.jump;
    assign idex_illegal     = r_idex.illegal;
    assign idex_funct3      = r_idex.funct3;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard bench for id_stage with hand-derived expected ID/EX contents
module tb_id_stage;

    typedef struct {
        logic        full;
        logic        valid;
        logic [31:0] pc, imm, d1, d2;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic [7:0]  ctl;
        logic [2:0]  f3;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = 32'b0;
    logic [31:0] if_pc = 32'b0;
    logic        flush = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rd = 5'b0;
    logic [4:0]  rf_src1, rf_src2;
    logic [31:0] rf_data1, rf_data2;
    logic        stall, idex_valid;
    logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    logic [3:0]  idex_alu_op;
    logic        idex_alu_src_imm, idex_alu_src_pc, idex_reg_write, idex_mem_read;
    logic        idex_mem_write, idex_branch, idex_jump, idex_illegal;
    logic [2:0]  idex_funct3;
    logic [31:0] regs [32];

    assign rf_data1 = (rf_src1 == 5'd0) ? 32'b0 : regs[rf_src1];
    assign rf_data2 = (rf_src2 == 5'd0) ? 32'b0 : regs[rf_src2];

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .rf_src1(rf_src1), .rf_src2(rf_src2), .rf_data1(rf_data1), .rf_data2(rf_data2),
        .stall(stall), .idex_valid(idex_valid), .idex_pc(idex_pc),
        .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_alu_op(idex_alu_op),
        .idex_alu_src_imm(idex_alu_src_imm), .idex_alu_src_pc(idex_alu_src_pc),
        .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
        .idex_mem_write(idex_mem_write), .idex_branch(idex_branch), .idex_jump(idex_jump),
        .idex_illegal(idex_illegal), .idex_funct3(idex_funct3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ent(input logic [31:0] pc, imm, input logic [4:0] rs1, rs2, rd,
                                 input logic [3:0] alu, input logic [7:0] ctl, input logic [2:0] f3,
                                 input logic [31:0] d1, d2);
        exp_t e;
        e.full = 1'b1; e.valid = 1'b1; e.pc = pc; e.imm = imm; e.rs1 = rs1; e.rs2 = rs2;
        e.rd = rd; e.alu = alu; e.ctl = ctl; e.f3 = f3; e.d1 = d1; e.d2 = d2;
        return e;
    endfunction

    function automatic exp_t bub();
        exp_t e;
        e = ent(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        e.valid = 1'b0;
        return e;
    endfunction

    function automatic exp_t vonly();
        exp_t e;
        e = bub();
        e.full = 1'b0;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        check("valid", idex_valid, e.valid);
        if (e.full) begin
            check("pc", idex_pc, e.pc);
            check("imm", idex_imm, e.imm);
            check("rs1", idex_rs1, e.rs1);
            check("rs2", idex_rs2, e.rs2);
            check("rd", idex_rd, e.rd);
            check("alu_op", idex_alu_op, e.alu);
            check("ctl", {idex_alu_src_imm, idex_alu_src_pc, idex_reg_write, idex_mem_read,
                          idex_mem_write, idex_branch, idex_jump, idex_illegal}, e.ctl);
            check("funct3", idex_funct3, e.f3);
            check("rs1_data", idex_rs1_data, e.d1);
            check("rs2_data", idex_rs2_data, e.d2);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sb.size() == 0) check("sb_size", 0, 1);
        else compare(sb.pop_front());
    endtask

    // e is what ID/EX should hold two edges after this drive
    task automatic step(input logic v, input logic [31:0] ins, pc, input logic fl, emr,
                        input logic [4:0] erd, input logic exp_stall, input exp_t e);
        if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_mem_read = emr; ex_rd = erd;
        #1;
        check("stall", stall, exp_stall);
        sb.push_back(e);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'b0;
        regs[1] = 32'h7;
        regs[2] = 32'h9;
        #2;
        compare(bub());
        check("stall_rst", stall, 0);
        #10 rst_n = 1'b1;
        sb.push_back(vonly());
        step(1, 32'h00500093, 0,  0, 0, 0, 0, ent(0, 5, 0, 0, 1, 0, 8'hA0, 0, 0, 0));
        step(1, 32'hFE208CE3, 4,  0, 0, 0, 0, ent(4, 32'hFFFFFFF8, 1, 2, 0, 1, 8'h04, 0, 7, 9));
        step(1, 32'h123452B7, 8,  0, 0, 0, 0, ent(8, 32'h12345000, 0, 0, 5, 10, 8'hA0, 0, 0, 0));
        check("rf_src1_lui", rf_src1, 0);
        step(1, 32'h00008233, 12, 0, 0, 0, 0, ent(12, 0, 1, 0, 4, 0, 8'h20, 0, 32'hAA, 0));
        regs[1] = 32'hAA;
        step(1, 32'h0000007F, 16, 0, 1, 0, 0, ent(16, 0, 0, 0, 0, 0, 8'h01, 0, 0, 0));
        step(1, 32'h001101B3, 20, 0, 0, 0, 0, bub());
        step(1, 32'hFFF04313, 24, 0, 1, 2, 1, ent(20, 0, 2, 1, 3, 0, 8'h20, 0, 9, 32'hAA));
        step(1, 32'hFFF04313, 24, 0, 0, 0, 0, ent(24, 32'hFFFFFFFF, 0, 0, 6, 5, 8'hA0, 4, 0, 0));
        step(1, 32'h401103B3, 28, 0, 0, 0, 0, bub());
        step(1, 32'h00500093, 32, 1, 1, 2, 0, vonly());
        step(1, 32'h4030D413, 44, 0, 0, 0, 0, ent(44, 32'h403, 1, 0, 8, 7, 8'hA0, 5, 32'hAA, 0));
        step(1, 32'h40000493, 48, 0, 0, 0, 0, ent(48, 32'h400, 0, 0, 9, 0, 8'hA0, 0, 0, 0));
        step(1, 32'h0020A423, 52, 0, 0, 0, 0, ent(52, 8, 1, 2, 0, 0, 8'h88, 2, 32'hAA, 9));
        step(1, 32'hFFDFF0EF, 56, 0, 0, 0, 0, ent(56, 32'hFFFFFFFC, 0, 0, 1, 0, 8'hA2, 0, 0, 0));
        step(1, 32'h00412503, 60, 0, 0, 0, 0, ent(60, 4, 2, 0, 10, 0, 8'hB0, 2, 9, 0));
        step(0, 32'h0,        64, 0, 0, 0, 0, vonly());
        tick();
        if_valid = 1'b1; if_instr = 32'h001101B3; if_pc = 68;
        @(posedge clk);
        #1;
        ex_mem_read = 1'b1; ex_rd = 5'd2;
        #1;
        check("stall_pre_rst", stall, 1);
        rst_n = 1'b0;
        #1;
        check("stall_mid_rst", stall, 0);
        check("valid_mid_rst", idex_valid, 0);
        check("pc_mid_rst", idex_pc, 0);
        check("rf_src1_mid_rst", rf_src1, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage RV32I pipeline. Owns the IF/ID and ID/EX pipeline registers and decodes the IF/ID instruction into control fields and immediate. Drives the register-file read addresses and captures the returned operands; same-cycle write-back forwarding is already resolved inside the register file. Detects load-use hazards, stalls fetch, and inserts bubbles on hazard or branch flush.

## Interface
- Parameters: none; opcode, ALU-op and immediate-type constants come from `cpu_pkg`.
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `if_valid`  in  1  fetch presents a valid instruction
- `if_instr`  in  32  fetched instruction
- `if_pc`  in  32  PC of `if_instr`
- `flush`  in  1  taken branch/jump resolved in EX; kill younger instructions
- `ex_mem_read`  in  1  instruction currently in EX is a load
- `ex_rd`  in  5  destination register of the EX instruction
- `rf_src1`, `rf_src2`  out  5  register-file read addresses (combinational from IF/ID)
- `rf_data1`, `rf_data2`  in  32  register-file read data
- `stall`  out  1  hold PC and fetch (combinational)
- `idex_valid`  out  1  ID/EX holds a real instruction
- `idex_pc`, `idex_rs1_data`, `idex_rs2_data`, `idex_imm`  out  32 each
- `idex_rs1`, `idex_rs2`, `idex_rd`  out  5 each
- `idex_alu_op`  out  4  `alu_op_t`
- `idex_alu_src_imm`, `idex_alu_src_pc`, `idex_reg_write`, `idex_mem_read`, `idex_mem_write`, `idex_branch`, `idex_jump`, `idex_illegal`  out  1 each
- `idex_funct3`  out  3  branch condition / memory size

## Operation
- IF/ID register fields: `valid`, `instr`, `pc`. It loads `if_*` each cycle unless `stall`=1. When `flush`=1, `valid` is cleared to 0.
- Decode uses the IF/ID instruction. Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Immediates:
  - I, S, B and J types are sign-extended from bit 31.
  - U type is `{instr[31:12],12'b0}`.
  - B and J types have bit 0 forced to 0.
- `alu_op` values: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB.
  - SUB and SRA are selected by `instr[30]`. For OP-IMM, `instr[30]` is honoured only when funct3=101.
  - LUI uses PASSB with the immediate.
  - AUIPC, JAL and JALR use ADD. AUIPC sets `alu_src_pc`.
  - LOAD and STORE use ADD with the immediate (address calculation).
  - BRANCH uses SUB.
- Register-use masks:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by BRANCH, STORE and OP only.
  - Unused source addresses are driven as 0 on `rf_src*` and `idex_rs*`.
- `reg_write` is 0 when rd=x0.
- An unknown opcode sets `illegal`=1 and forces all other control bits to 0. `idex_valid` is still 1, so EX can trap.
- Load-use hazard: `hazard = ifid.valid & ex_mem_read & ex_rd≠0 & ((use_rs1 & rs1==ex_rd) | (use_rs2 & rs2==ex_rd))`.
  - `stall = hazard & ~flush`.
- ID/EX update, highest priority first:
  1. `flush`: bubble.
  2. `hazard`: bubble.
  3. Otherwise: load the decoded IF/ID contents, with `idex_valid = ifid.valid`.
- A bubble has `valid`=0 and all control bits 0. Data fields are don't-care and are driven 0.

## Timing
- Reset (asynchronous): IF/ID and every `idex_*` output go to 0, and `stall`=0.
- Latency: an instruction on `if_*` at edge N is in IF/ID after N and appears on `idex_*` after edge N+1.
- The register file is read combinationally in the IF/ID cycle. A write-back in that same cycle is visible through the register-file bypass.
- A load-use stall lasts exactly 1 cycle. After the bubble the load has left EX, so `hazard` drops and the dependent instruction proceeds. Its operand comes from MEM/WB forwarding, which is outside this block.
- `flush` and `hazard` in the same cycle: flush wins, `stall`=0, both registers are bubbled.
- `if_valid`=0 propagates as `idex_valid`=0 with no stall, because the hazard term requires `ifid.valid`.
- Reset asserted mid-stall clears everything immediately. There is no pending state.

## Structure
- `cpu_pkg` contents:
  - `opcode_t` constants.
  - `alu_op_t` enum, 4 bits.
  - `imm_type_t` enum (I/S/B/U/J/NONE).
  - `NOP_INSTR` = 32'h00000013.
  - `idex_t` packed struct. It is shared with the EX stage.
- One combinational sub-module, `instr_decoder`. It maps the instruction to control fields, `imm_type`, `use_rs1`/`use_rs2` and the immediate.
- `id_stage` holds both pipeline registers, the hazard logic and the priority muxing.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093) with pc=0 → two edges later: `idex_valid`=1, `idex_imm`=5, `idex_rd`=1, ADD, `alu_src_imm`=1, `reg_write`=1.
- `lw x2,0(x1)` in EX (`ex_mem_read`=1, `ex_rd`=2) while `add x3,x2,x1` is in IF/ID → `stall`=1 for one cycle, one bubble in ID/EX, then the add issues with `idex_rs1`=2.
- `flush`=1 together with a hazard → `stall`=0; next cycle `idex_valid`=0 and the IF/ID valid bit is 0.
- `beq x1,x2,-8` (0xFE208CE3) → `idex_imm`=0xFFFFFFF8, `branch`=1, SUB, `funct3`=000, `reg_write`=0.
- `lui x5,0x12345` → `idex_imm`=0x12345000, PASSB, `rf_src1`=0; same-cycle write-back of x1=0xAA then `add x4,x1,x0` → `idex_rs1_data`=0xAA.
- Opcode 0x7F → `idex_illegal`=1, `idex_valid`=1, all other control bits 0; load into x0 in EX (`ex_rd`=0) → no stall.
